game_session_ctrl: RTL and testbench

Parametrised game session controller that supersedes the single-player play/wait FSM. It sits between the synchronised button inputs and the game core. It collects player joins during a timed join window, then runs a fixed number of rounds with an optional pause. At session end it drives a multi-cycle `resetMaster` pulse that returns the game core to its idle state.

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_session_ctrl_if.sv | 39 +++
 rtl/btn_edge_sync.sv | 38 +++
 rtl/game_session_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_session_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared state encoding and default parameters for the session
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        S_WAIT       = 3'd0,
        S_JOIN       = 3'd1,
        S_PLAY       = 3'd2,
        S_PAUSE      = 3'd3,
        S_ROUND_END  = 3'd4,
        S_RESET_HOLD = 3'd5
    } session_state_t;

    localparam int DEF_NUM_PLAYERS  = 4;
    localparam int DEF_NUM_ROUNDS   = 3;
    localparam int DEF_JOIN_CYCLES  = 8;
    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_SYNC_STAGES  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_session_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_session_ctrl_if
// Brief    : Button inputs, core handshakes and session outputs of the
//            session controller; master is the controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface game_session_ctrl_if
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int NUM_ROUNDS  = DEF_NUM_ROUNDS
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);

    logic                   ready;
    logic [NUM_PLAYERS-1:0] startBtn;
    logic                   pauseBtn;
    logic                   roundOver;
    logic                   gameOverReq;
    logic                   startGameNow;
    logic                   gamePlaying;
    logic                   paused;
    logic [NUM_PLAYERS-1:0] playerMask;
    logic [RW-1:0]          roundNum;
    logic                   resetMaster;

    modport master (
        input  ready, startBtn, pauseBtn, roundOver, gameOverReq,
        output startGameNow, gamePlaying, paused, playerMask, roundNum, resetMaster
    );

    modport slave (
        output ready, startBtn, pauseBtn, roundOver, gameOverReq,
        input  startGameNow, gamePlaying, paused, playerMask, roundNum, resetMaster
    );

endinterface
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge_sync
// Brief    : Multi-flop synchroniser for a raw button followed by a
//            rising-edge detector (one-cycle pulse).
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic CLOCK_50,
    input  wire logic reset_n,
    input  wire logic raw,
    output logic      edge_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_session_ctrl
// Brief    : Multi-player session controller: timed join window, N rounds,
//            optional pause (GAME_SESSION_PAUSE_EN) and a resetMaster pulse.
// Revision : 1.0 - initial release
// ============================================================================
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
    parameter int NUM_ROUNDS   = DEF_NUM_ROUNDS,
    parameter int JOIN_CYCLES  = DEF_JOIN_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  wire logic            CLOCK_50,
    input  wire logic            reset_n,
    game_session_ctrl_if.master  bus
);

    localparam int RW         = $clog2(NUM_ROUNDS + 1);
    localparam int MAX_CYCLES = max_int(JOIN_CYCLES, RESET_CYCLES);
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] JOIN_LOAD  = TW'(JOIN_CYCLES - 1);
    localparam logic [TW-1:0] RESET_LOAD = TW'(RESET_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

    logic [NUM_PLAYERS-1:0] start_edge;

    generate
        for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_start_sync
            btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
                .CLOCK_50 (CLOCK_50),
                .reset_n  (reset_n),
                .raw      (bus.startBtn[i]),
                .edge_out (start_edge[i])
            );
        end
    endgenerate

`ifdef GAME_SESSION_PAUSE_EN
    logic pause_edge;
    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pause_sync (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .raw      (bus.pauseBtn),
        .edge_out (pause_edge)
    );
`else
    logic unused_pause_btn;
    assign unused_pause_btn = bus.pauseBtn;
`endif

    session_state_t         state_q, state_d;
    logic [NUM_PLAYERS-1:0] mask_q, mask_d;
    logic [RW-1:0]          round_q, round_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   sgn_q, sgn_d;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        round_d = round_q;
        timer_d = timer_q;
        sgn_d   = 1'b0;
        case (state_q)
            S_WAIT: begin
                // edges without ready are dropped, never remembered
                if (bus.ready && (|start_edge)) begin
                    state_d = S_JOIN;
                    mask_d  = mask_q | start_edge;
                    timer_d = JOIN_LOAD;
                end
            end
            S_JOIN: begin
                mask_d = mask_q | start_edge;
                if (timer_q == '0) begin
                    state_d = S_PLAY;
                    round_d = RW'(1);
                    sgn_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.gameOverReq || (bus.roundOver && (round_q == LAST_ROUND))) begin
                    state_d = S_RESET_HOLD;
                    timer_d = RESET_LOAD;
                end else if (bus.roundOver) begin
                    state_d = S_ROUND_END;
`ifdef GAME_SESSION_PAUSE_EN
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
`endif
                end
            end
            S_ROUND_END: begin
                state_d = S_PLAY;
                round_d = round_q + 1'b1;
                sgn_d   = 1'b1;
            end
`ifdef GAME_SESSION_PAUSE_EN
            S_PAUSE: begin
                if (pause_edge) begin
                    state_d = S_PLAY;
                end else if (bus.gameOverReq) begin
                    state_d = S_RESET_HOLD;
                    timer_d = RESET_LOAD;
                end
            end
`endif
            S_RESET_HOLD: begin
                if (timer_q == '0) begin
                    state_d = S_WAIT;
                    mask_d  = '0;
                    round_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            mask_q  <= '0;
            round_q <= '0;
            timer_q <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            round_q <= round_d;
            timer_q <= timer_d;
            sgn_q   <= sgn_d;
        end
    end

    assign bus.startGameNow = sgn_q;
    assign bus.gamePlaying  = (state_q == S_PLAY);
`ifdef GAME_SESSION_PAUSE_EN
    assign bus.paused       = (state_q == S_PAUSE);
`else
    assign bus.paused       = 1'b0;
`endif
    assign bus.resetMaster  = (state_q == S_RESET_HOLD);
    assign bus.playerMask   = mask_q;
    assign bus.roundNum     = round_q;

endmodule
`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_session_ctrl
// Brief    : Cycle-accurate vector table with expected-output scoreboard for
//            game_session_ctrl; pause rows adapt to GAME_SESSION_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_session_ctrl;

`ifdef GAME_SESSION_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        int         n;
        logic       rdy;
        logic [3:0] btn;
        logic       pau;
        logic       ro;
        logic       go;
        logic [9:0] exp_out;
    } vec_t;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    game_session_ctrl_if #(.NUM_PLAYERS(4), .NUM_ROUNDS(3)) bus ();

    game_session_ctrl #(
        .NUM_PLAYERS  (4),
        .NUM_ROUNDS   (3),
        .JOIN_CYCLES  (8),
        .RESET_CYCLES (4),
        .SYNC_STAGES  (2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    vec_t       tbl[$];
    logic [9:0] exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    // packed as {startGameNow, gamePlaying, paused, playerMask, roundNum, resetMaster}
    function automatic logic [9:0] outs(bit sgn, bit gp, bit ps, logic [3:0] m, logic [1:0] r, bit rm);
        return {sgn, gp, ps, m, r, rm};
    endfunction

    function automatic void add(int n, bit rdy, logic [3:0] btn, bit pau, bit ro, bit go,
                                bit sgn, bit gp, bit ps, logic [3:0] m, logic [1:0] r, bit rm);
        vec_t v;
        v.n = n; v.rdy = rdy; v.btn = btn; v.pau = pau; v.ro = ro; v.go = go;
        v.exp_out = outs(sgn, gp, ps, m, r, rm);
        tbl.push_back(v);
    endfunction

    function automatic logic [9:0] dut_outs();
        return {bus.startGameNow, bus.gamePlaying, bus.paused, bus.playerMask,
                bus.roundNum, bus.resetMaster};
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got {sgn,gp,ps,mask,rnd,rm}=%b, expected %b", name, act, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pr;
        pr = PE ? 2'd1 : 2'd2;

        // session A: two joins, three rounds, natural end
        add(2, 1, 4'b0001, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(2, 1, 4'b0001, 0, 0, 0,  0, 0, 0, 4'b0001, 2'd0, 0);
        add(2, 1, 4'b0101, 0, 0, 0,  0, 0, 0, 4'b0001, 2'd0, 0);
        add(4, 1, 4'b0101, 0, 0, 0,  0, 0, 0, 4'b0101, 2'd0, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  1, 1, 0, 4'b0101, 2'd1, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  0, 1, 0, 4'b0101, 2'd1, 0);
        add(1, 1, 4'b0101, 0, 1, 0,  0, 0, 0, 4'b0101, 2'd1, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  1, 1, 0, 4'b0101, 2'd2, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  0, 1, 0, 4'b0101, 2'd2, 0);
        add(1, 1, 4'b0101, 0, 1, 0,  0, 0, 0, 4'b0101, 2'd2, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  1, 1, 0, 4'b0101, 2'd3, 0);
        add(1, 1, 4'b0101, 0, 0, 0,  0, 1, 0, 4'b0101, 2'd3, 0);
        add(1, 1, 4'b0101, 0, 1, 0,  0, 0, 0, 4'b0101, 2'd3, 1);
        add(3, 1, 4'b0101, 0, 0, 0,  0, 0, 0, 4'b0101, 2'd3, 1);
        add(1, 1, 4'b0101, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        // press while not ready, then raise ready with the button still held
        add(3, 1, 4'b0000, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(5, 0, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(4, 1, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        // session C: abort with gameOverReq and roundOver together
        add(3, 1, 4'b0000, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(2, 1, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(8, 1, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0010, 2'd0, 0);
        add(1, 1, 4'b0010, 0, 0, 0,  1, 1, 0, 4'b0010, 2'd1, 0);
        add(1, 1, 4'b0010, 0, 0, 0,  0, 1, 0, 4'b0010, 2'd1, 0);
        add(1, 1, 4'b0010, 0, 1, 1,  0, 0, 0, 4'b0010, 2'd1, 1);
        add(3, 1, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0010, 2'd1, 1);
        add(1, 1, 4'b0010, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        // session D: pause toggle with a roundOver while paused
        add(2, 1, 4'b1000, 0, 0, 0,  0, 0, 0, 4'b0000, 2'd0, 0);
        add(8, 1, 4'b1000, 0, 0, 0,  0, 0, 0, 4'b1000, 2'd0, 0);
        add(1, 1, 4'b1000, 0, 0, 0,  1, 1, 0, 4'b1000, 2'd1, 0);
        add(1, 1, 4'b1000, 0, 0, 0,  0, 1, 0, 4'b1000, 2'd1, 0);
        add(2, 1, 4'b1000, 1, 0, 0,  0, 1, 0, 4'b1000, 2'd1, 0);
        add(1, 1, 4'b1000, 1, 0, 0,  0, !PE, PE, 4'b1000, 2'd1, 0);
        add(1, 1, 4'b1000, 1, 1, 0,  0, 0, PE, 4'b1000, 2'd1, 0);
        add(1, 1, 4'b1000, 0, 0, 0,  !PE, !PE, PE, 4'b1000, pr, 0);
        add(2, 1, 4'b1000, 0, 0, 0,  0, !PE, PE, 4'b1000, pr, 0);
        add(2, 1, 4'b1000, 1, 0, 0,  0, !PE, PE, 4'b1000, pr, 0);
        add(1, 1, 4'b1000, 1, 0, 0,  0, 1, 0, 4'b1000, pr, 0);
        add(1, 1, 4'b0000, 0, 0, 1,  0, 0, 0, 4'b1000, pr, 1);
        add(1, 1, 4'b0000, 0, 0, 0,  0, 0, 0, 4'b1000, pr, 1);

        bus.ready = 1'b0; bus.startBtn = '0; bus.pauseBtn = 1'b0;
        bus.roundOver = 1'b0; bus.gameOverReq = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 check("reset_state", dut_outs(), 10'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge CLOCK_50);
                bus.ready       = tbl[i].rdy;
                bus.startBtn    = tbl[i].btn;
                bus.pauseBtn    = tbl[i].pau;
                bus.roundOver   = tbl[i].ro;
                bus.gameOverReq = tbl[i].go;
                exp_q.push_back(tbl[i].exp_out);
                @(posedge CLOCK_50);
                #1;
                if (exp_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL scoreboard_empty: row %0d got %b, required an expected entry", i, dut_outs());
                end else begin
                    check($sformatf("row%0d_cyc%0d", i, k), dut_outs(), exp_q.pop_front());
                end
            end
        end

        // now in the 2nd cycle of RESET_HOLD: asynchronous reset must clear at once
        reset_n = 1'b0;
        #1 check("async_reset_mid_hold", dut_outs(), 10'd0);
        @(posedge CLOCK_50);
        #1 check("reset_held", dut_outs(), 10'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK_50);
            #1 check($sformatf("post_reset_wait%0d", k), dut_outs(), 10'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
